ihex_writer: RTL and testbench
==============================

IHEX_WRITER -- requirements
Module: ihex_writer

Interface
REQ-001 SHALL have parameter RECORD_LEN, default 16, max data bytes per record (1..255).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_start  input  1  single-cycle dump request.
REQ-005 SHALL have port i_start_addr  input  16  first memory address.
REQ-006 SHALL have port i_length  input  16  byte count, 0..0xFFFF.
REQ-007 SHALL have port o_mem_read_en  output  1  memory read strobe.
REQ-008 SHALL have port o_mem_addr  output  16  memory read address.
REQ-009 SHALL have port i_mem_data  input  8  read data, valid the cycle after o_mem_read_en.
REQ-010 SHALL have port o_tx_data  output  8  ASCII character to UART transmitter.
REQ-011 SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-012 SHALL have port i_tx_ready  input  1  transmitter accepts character.
REQ-013 SHALL have port o_idle  output  1  high when no dump is in progress.
REQ-014 SHALL have port o_done  output  1  one-cycle pulse after the EOF record's final character is accepted.

Function
REQ-015 SHALL emit Intel HEX type-00 records ':' LL AAAA 00 DD.. CC EOL, then EOF record ":00000001FF" EOL.
REQ-016 SHALL encode hex digits as uppercase ASCII, high nibble first.
REQ-017 SHALL set checksum CC = (0x100 - (8-bit sum of LL, AH, AL, type, data bytes)) mod 0x100.
REQ-018 SHALL set each record's LL = min(RECORD_LEN, remaining bytes, 0x10000 - current address).
REQ-019 SHALL never let a record cross 0xFFFF; the next record starts at 0x0000 (address wraps mod 2^16).
REQ-020 SHALL, when i_length = 0, emit only the EOF record.
REQ-021 SHALL accept i_start only while o_idle=1; i_start while busy is ignored; i_start_addr/i_length are latched on acceptance.
REQ-022 SHALL transfer a character on a cycle where o_tx_valid && i_tx_ready; o_tx_data and o_tx_valid are held stable until transfer.
REQ-023 SHALL fetch each data byte with a single o_mem_read_en pulse before its first nibble is presented; no read occurs while a character is pending.
REQ-024 SHALL use states S_IDLE, S_COLON, S_LEN, S_ADDR_HI, S_ADDR_LO, S_TYPE, S_FETCH, S_DATA, S_CSUM, S_EOL, S_EOF, S_DONE; each byte state emits two characters via a nibble-phase flag.
REQ-025 SHALL transition S_CSUM -> S_EOL -> S_COLON when bytes remain, else S_EOF -> S_DONE -> S_IDLE.
REQ-026 SHALL take the record type from S_TYPE (00 data, 01 EOF) so the EOF record reuses the byte/checksum path.

Reset
REQ-027 SHALL on i_rst force state S_IDLE, o_tx_valid=0, o_mem_read_en=0, o_done=0, o_idle=1, o_tx_data=0, o_mem_addr=0, immediately and asynchronously.
REQ-028 SHALL discard any partial record on reset mid-dump; the next i_start begins a fresh dump.

Configuration
REQ-029 SHALL, with IHEX_WRITER_CRLF_EN defined, end each record with CR (0x0D) then LF (0x0A).
REQ-030 SHALL, without IHEX_WRITER_CRLF_EN, end each record with LF (0x0A) only.

Structure
REQ-031 SHALL place record-type constants (IHEX_TYPE_DATA=00, IHEX_TYPE_EOF=01), ASCII constants and a nibble-to-ASCII function in shared package ihex_pkg, reused by the Intel HEX parser.
REQ-032 SHALL be a single module with no sub-module; hex conversion uses the package function.

Verification
REQ-033 SHALL test: addr 0x0F00, len 3, mem 01 02 03 -> ":030F0000010203E8" EOL, ":00000001FF" EOL, o_done pulse.
REQ-034 SHALL test: len 0 -> only ":00000001FF" EOL, no o_mem_read_en pulses.
REQ-035 SHALL test: addr 0x0100, len 20, RECORD_LEN 16 -> LL=10 at 0100, LL=04 at 0110, then EOF.
REQ-036 SHALL test: addr 0xFFFC, len 8 -> LL=04 at FFFC, LL=04 at 0000, then EOF.
REQ-037 SHALL test: i_tx_ready low 5 cycles mid-data -> o_tx_data stable, no character lost or duplicated; i_start while busy ignored.
REQ-038 SHALL test: i_rst asserted mid-record -> o_tx_valid=0 and o_idle=1 the same cycle; a new i_start yields a complete correct dump.

Source files
------------

// File: rtl/ihex_pkg.sv
// Shared Intel HEX definitions: record types, ASCII codes, nibble encoder and
// the writer FSM state encoding. Also used by the Intel HEX parser.
package ihex_pkg;

    localparam logic [7:0] IHEX_TYPE_DATA = 8'h00;
    localparam logic [7:0] IHEX_TYPE_EOF  = 8'h01;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic [3:0] {
        S_IDLE, S_COLON, S_LEN, S_ADDR_HI, S_ADDR_LO, S_TYPE,
        S_FETCH, S_DATA, S_CSUM, S_EOL, S_EOF, S_DONE
    } ihex_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_ZERO + {4'h0, nib};
        else
            return ASCII_UPPER_A + {4'h0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/ihex_writer.sv
// Streams a memory range out as Intel HEX text over a ready/valid character port.
// Build option: define IHEX_WRITER_CRLF_EN to end lines with CR LF instead of LF.
//
// state      | meaning
// S_IDLE     | waiting for i_start
// S_COLON    | emit ':' and size the record
// S_LEN      | emit LL
// S_ADDR_HI  | emit address high byte (00 for EOF)
// S_ADDR_LO  | emit address low byte (00 for EOF)
// S_TYPE     | emit record type
// S_FETCH    | one-cycle memory read strobe
// S_DATA     | capture read byte, then emit it
// S_CSUM     | emit checksum
// S_EOL      | emit line ending
// S_EOF      | arm the EOF record, then reuse the record path
// S_DONE     | one-cycle done pulse
module ihex_writer
    import ihex_pkg::*;
#(
    parameter int unsigned RECORD_LEN = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_start_addr,
    input  logic [15:0] i_length,
    output logic        o_mem_read_en,
    output logic [15:0] o_mem_addr,
    input  logic [7:0]  i_mem_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_idle,
    output logic        o_done
);

`ifdef IHEX_WRITER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    localparam logic [16:0] REC_LEN17 = 17'(RECORD_LEN);
    localparam logic [7:0]  REC_LEN8  = 8'(RECORD_LEN);

    ihex_state_t state, state_next;

    logic        nib;
    logic [15:0] addr;
    logic [15:0] remaining;
    logic [7:0]  rec_len;
    logic [7:0]  cnt;
    logic [7:0]  csum;
    logic [7:0]  data_byte;
    logic        fetch_pending;
    logic        eof_rec;

    logic [7:0]  byte_val;
    logic [7:0]  ll;
    logic [16:0] room;
    logic [16:0] rem17;
    logic        xfer;
    logic        char_last;
    logic        eol_last;

    always_comb begin
        room  = 17'h10000 - {1'b0, addr};
        rem17 = {1'b0, remaining};
        if (eof_rec)
            ll = 8'h00;
        else if (rem17 <= room && rem17 < REC_LEN17)
            ll = remaining[7:0];
        else if (room < REC_LEN17)
            ll = room[7:0];
        else
            ll = REC_LEN8;
    end

    always_comb begin
        byte_val = 8'h00;
        case (state)
            S_LEN:     byte_val = rec_len;
            S_ADDR_HI: byte_val = eof_rec ? 8'h00 : addr[15:8];
            S_ADDR_LO: byte_val = eof_rec ? 8'h00 : addr[7:0];
            S_TYPE:    byte_val = eof_rec ? IHEX_TYPE_EOF : IHEX_TYPE_DATA;
            S_DATA:    byte_val = data_byte;
            S_CSUM:    byte_val = 8'h00 - csum;
            default:   byte_val = 8'h00;
        endcase
    end

    assign o_tx_valid = (state inside {S_COLON, S_LEN, S_ADDR_HI, S_ADDR_LO,
                                       S_TYPE, S_CSUM, S_EOL})
                        || (state == S_DATA && !fetch_pending);
    assign xfer      = o_tx_valid && i_tx_ready;
    assign eol_last  = CRLF ? nib : 1'b1;
    assign char_last = (state == S_COLON) ? 1'b1 :
                       (state == S_EOL)   ? eol_last : nib;

    always_comb begin
        o_tx_data = 8'h00;
        case (state)
            S_IDLE, S_FETCH, S_EOF, S_DONE: o_tx_data = 8'h00;
            S_COLON: o_tx_data = ASCII_COLON;
            S_EOL:   o_tx_data = (CRLF && !nib) ? ASCII_CR : ASCII_LF;
            default: o_tx_data = nibble_to_ascii(nib ? byte_val[3:0] : byte_val[7:4]);
        endcase
    end

    assign o_mem_read_en = (state == S_FETCH);
    assign o_mem_addr    = addr;
    assign o_idle        = (state == S_IDLE);
    assign o_done        = (state == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (i_start) state_next = (i_length == 16'h0000) ? S_EOF : S_COLON;
            S_COLON:   if (xfer) state_next = S_LEN;
            S_LEN:     if (xfer && nib) state_next = S_ADDR_HI;
            S_ADDR_HI: if (xfer && nib) state_next = S_ADDR_LO;
            S_ADDR_LO: if (xfer && nib) state_next = S_TYPE;
            S_TYPE:    if (xfer && nib) state_next = eof_rec ? S_CSUM : S_FETCH;
            S_FETCH:   state_next = S_DATA;
            S_DATA:    if (xfer && nib) state_next = (cnt == 8'd1) ? S_CSUM : S_FETCH;
            S_CSUM:    if (xfer && nib) state_next = S_EOL;
            // After the EOF record's line ending the dump is finished.
            S_EOL: if (xfer && eol_last) begin
                if (eof_rec)
                    state_next = S_DONE;
                else if (remaining != 16'h0000)
                    state_next = S_COLON;
                else
                    state_next = S_EOF;
            end
            S_EOF:     state_next = S_COLON;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            nib           <= 1'b0;
            addr          <= 16'h0000;
            remaining     <= 16'h0000;
            rec_len       <= 8'h00;
            cnt           <= 8'h00;
            csum          <= 8'h00;
            data_byte     <= 8'h00;
            fetch_pending <= 1'b0;
            eof_rec       <= 1'b0;
        end else begin
            if (xfer)
                nib <= !char_last;
            case (state)
                S_IDLE: if (i_start) begin
                    addr      <= i_start_addr;
                    remaining <= i_length;
                    eof_rec   <= 1'b0;
                    nib       <= 1'b0;
                end
                S_COLON: if (xfer) begin
                    rec_len <= ll;
                    cnt     <= ll;
                    csum    <= 8'h00;
                end
                S_LEN, S_ADDR_HI, S_ADDR_LO, S_TYPE:
                    if (xfer && nib) csum <= csum + byte_val;
                S_FETCH: fetch_pending <= 1'b1;
                S_DATA: begin
                    if (fetch_pending) begin
                        data_byte     <= i_mem_data;
                        fetch_pending <= 1'b0;
                        addr          <= addr + 16'd1;
                        remaining     <= remaining - 16'd1;
                    end else if (xfer && nib) begin
                        csum <= csum + byte_val;
                        cnt  <= cnt - 8'd1;
                    end
                end
                S_EOF: eof_rec <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ihex_writer.sv
// Scoreboard bench for ihex_writer: directed dumps with hand-computed records.
module tb_ihex_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = 16'h0000;
    logic [15:0] length = 16'h0000;
    logic        mem_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        idle;
    logic        done;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q [$];

    int passed = 0;
    int total = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int stall_checks = 0;
    bit stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    ihex_writer #(.RECORD_LEN(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(start_addr),
        .i_length(length), .o_mem_read_en(mem_read_en), .o_mem_addr(mem_addr),
        .i_mem_data(mem_data), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_idle(idle), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_read_en) mem_data <= mem[mem_addr];

    task automatic check(input string name, input int actual, input int required);
        total++;
        if (actual == required) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, required);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_eol();
`ifdef IHEX_WRITER_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_line(input string s);
        push_str(s);
        push_eol();
    endtask

    // Monitor: pops the scoreboard on every accepted character.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                stall_checks++;
                check("stall_valid_held", int'(tx_valid), 1);
                check("stall_data_held", int'(tx_data), int'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_char", int'(tx_data), -1);
                end else begin
                    check("char", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (mem_read_en) begin
                rd_cnt++;
                if (tx_valid) check("read_while_pending", 1, 0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_dump(input logic [15:0] a, input logic [15:0] n,
                            input int exp_reads, input string tag);
        int rd0;
        int d0;
        rd0 = rd_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        check({tag, "_idle_before"}, int'(idle), 1);
        start = 1'b1; start_addr = a; length = n;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_mem_reads"}, rd_cnt - rd0, exp_reads);
        check({tag, "_idle_after"}, int'(idle), 1);
    endtask

    task automatic wait_chars(input int n);
        int c;
        c = 0;
        while (xfer_cnt < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        if (xfer_cnt < n) check("wait_chars_timeout", xfer_cnt, n);
    endtask

    task automatic push_case_0f00();
        push_line(":030F0000010203E8");
        push_line(":00000001FF");
    endtask

    task automatic push_case_0100();
        push_line(":10010000000102030405060708090A0B0C0D0E0F77");
        push_line(":0401100010111213A5");
        push_line(":00000001FF");
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0F00] = 8'h01; mem[16'h0F01] = 8'h02; mem[16'h0F02] = 8'h03;
        for (int i = 0; i < 20; i++) mem[16'h0100 + i] = 8'(i);
        mem[16'hFFFC] = 8'hAA; mem[16'hFFFD] = 8'hBB;
        mem[16'hFFFE] = 8'hCC; mem[16'hFFFF] = 8'hDD;
        mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
        mem[16'h0002] = 8'h33; mem[16'h0003] = 8'h44;

        #3;
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_read_en", int'(mem_read_en), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        push_case_0f00();
        run_dump(16'h0F00, 16'd3, 3, "len3");

        push_line(":00000001FF");
        run_dump(16'h1234, 16'd0, 0, "len0");

        push_case_0100();
        run_dump(16'h0100, 16'd20, 20, "len20");

        push_line(":04FFFC00AABBCCDDF3");
        push_line(":040000001122334452");
        push_line(":00000001FF");
        run_dump(16'hFFFC, 16'd8, 8, "wrap");

        // Back-pressure mid-data plus a start request while busy.
        push_case_0100();
        xfer_cnt = 0;
        stall_checks = 0;
        fork
            run_dump(16'h0100, 16'd20, 20, "stall");
            begin
                wait_chars(15);
                @(posedge clk); #1;
                tx_ready = 1'b0;
                start = 1'b1; start_addr = 16'h0F00; length = 16'd3;
                @(posedge clk); #1;
                start = 1'b0;
                repeat (4) @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        join
        check("stall_cycles_seen", int'(stall_checks >= 4), 1);

        // Reset in the middle of the second record.
        push_case_0100();
        xfer_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 16'h0100; length = 16'd20;
        @(posedge clk); #1;
        start = 1'b0;
        wait_chars(50);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        #1;
        check("midrst_tx_valid", int'(tx_valid), 0);
        check("midrst_idle", int'(idle), 1);
        check("midrst_read_en", int'(mem_read_en), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        push_case_0f00();
        run_dump(16'h0F00, 16'd3, 3, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
